spi_xfer_sequencer: RTL
=======================

Name: spi_xfer_sequencer

Overview:
Upstream feeder for the byte-level SPI driver. It buffers host TX bytes in a FIFO and issues one driver transfer per byte with a single-cycle start pulse. It captures each received byte into an RX FIFO. It also enforces a minimum idle gap between transfers, RX back-pressure, and a start-acknowledge timeout.

Parameters:
DEPTH, 8, TX and RX FIFO depth in bytes; power of 2, ≥2.
GAP_CYCLES, 2, minimum clk cycles from driver-busy fall to the next drv_start; 0 allowed.
START_TIMEOUT, 4, max clk cycles after drv_start for drv_en to rise before an error is flagged; ≥2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = sequencer may launch transfers
tx_data  in  8  host byte to transmit
tx_valid  in  1  host push request
tx_ready  out  1  TX FIFO not full
rx_data  out  8  head of RX FIFO (first-word-fall-through)
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  host pop
tx_level  out  $clog2(DEPTH)+1  TX FIFO occupancy
rx_level  out  $clog2(DEPTH)+1  RX FIFO occupancy
busy  out  1  state != IDLE
xfer_count  out  16  completed transfers, wraps 0xFFFF→0
err  out  1  sticky start-timeout flag
err_clr  in  1  clears err
drv_start  out  1  one-cycle start pulse to driver
drv_tx_data  out  8  byte for driver
drv_en  in  1  driver busy/chip-enable
drv_rx_data  in  8  driver received byte; valid in the final cycle drv_en is high

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - Both FIFOs emptied; state IDLE; counters 0.
  - Outputs: drv_start=0, drv_tx_data=0, err=0, xfer_count=0, tx_ready=1, rx_valid=0, rx_data=0, busy=0.
  - Reset mid-transfer abandons the byte; no RX push.
- FIFO handshakes:
  - Push on tx_valid&&tx_ready. Pop on rx_valid&&rx_ready.
  - tx_ready is derived from registered occupancy. A same-cycle internal pop does not admit a push into a full FIFO.
  - A push to an empty RX FIFO is visible on rx_data/rx_valid the next cycle.
- Launch condition (IDLE): enable && tx_level!=0 && rx_level<DEPTH.
- States:
  - IDLE → START when the launch condition holds.
  - START (1 cycle):
    - drv_start=1.
    - TX head popped into the drv_tx_data hold register the same cycle; the register stays stable until the next START.
    - → WAIT_ACK; the ack counter is cleared.
  - WAIT_ACK:
    - drv_en=1 → WAIT_DONE.
    - Counter reaches START_TIMEOUT → set err, byte discarded, no RX push, → GAP.
  - WAIT_DONE:
    - Every cycle drv_en=1, capture drv_rx_data into the last_rx register.
    - On drv_en=0 (falling edge): push last_rx to the RX FIFO, xfer_count+1, → GAP.
  - GAP: count GAP_CYCLES cycles, then → IDLE. With GAP_CYCLES=0, GAP lasts 1 cycle.
- Minimum spacing: next drv_start ≥ GAP_CYCLES+2 cycles after the drv_en fall.
- enable deasserted mid-transfer: the current transfer completes normally; no new launch.
- err_clr && timeout set in the same cycle: set wins.
- RX slot is guaranteed at launch (single in-flight), so no RX overflow path exists.
- drv_start is never asserted while drv_en=1.

Test Plan:
- Driver model: drv_en rises 1 cycle after drv_start, stays high 20 cycles, drv_rx_data=~tx byte in the last high cycle.
- Single byte: push 0xA5, enable=1 → one drv_start, drv_tx_data=0xA5; rx_data=0x5A, rx_valid=1; xfer_count=1; busy returns 0.
- Burst: push 0x01,0x02,0x03, GAP_CYCLES=2 → three starts in order; each start is ≥4 cycles after the previous drv_en fall; RX reads 0xFE,0xFD,0xFC; xfer_count=3.
- RX back-pressure: DEPTH=8, push 10 bytes, rx_ready=0:
  - Exactly 8 transfers complete; rx_level=8; tx_level=2; no further drv_start.
  - Pop one byte → the 9th transfer launches.
- Timeout: driver model never raises drv_en → err=1 START_TIMEOUT cycles after drv_start; byte dropped; rx_level=0; the next byte launches.
  - err_clr pulse → err=0.
  - err_clr coincident with a new timeout → err stays 1.
- Enable/reset mid-burst:
  - Drop enable during the 2nd of 4 transfers → 2nd completes; tx_level=2 held.
  - Reassert, then assert rst mid-WAIT_DONE → all FIFOs empty, drv_start=0, xfer_count=0, no RX push.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// spi_xfer_sequencer: TX/RX byte FIFOs feeding a byte-level SPI driver, one start pulse per byte,
// with an enforced idle gap, RX back-pressure and a sticky start-acknowledge timeout.
module spi_xfer_sequencer #(
   parameter int DEPTH = 8,
   parameter int GAP_CYCLES = 2,
   parameter int START_TIMEOUT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [7:0]               tx_data,
   input  logic                     tx_valid,
   output logic                     tx_ready,
   output logic [7:0]               rx_data,
   output logic                     rx_valid,
   input  logic                     rx_ready,
   output logic [$clog2(DEPTH):0]   tx_level,
   output logic [$clog2(DEPTH):0]   rx_level,
   output logic                     busy,
   output logic [15:0]              xfer_count,
   output logic                     err,
   input  logic                     err_clr,
   output logic                     drv_start,
   output logic [7:0]               drv_tx_data,
   input  logic                     drv_en,
   input  logic [7:0]               drv_rx_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   localparam logic [15:0] TO_LIM = 16'(START_TIMEOUT - 2);
   localparam logic [15:0] GAP_LIM = 16'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, START, WAIT_ACK, WAIT_DONE, GAP} state_t;
   state_t state, state_nx;
   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];
   logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
   logic [15:0] cnt;
   logic [7:0] last_rx;
   logic tx_push, tx_pop, rx_push, rx_pop, launch, timeout;
   assign tx_ready = tx_level != FULL;
   assign rx_valid = rx_level != '0;
   assign rx_data = rx_valid ? rx_mem[rx_rp] : 8'h00;
   assign busy = state != IDLE;
   assign tx_push = tx_valid && tx_ready;
   assign rx_pop = rx_valid && rx_ready;
   // never launch while the driver still holds drv_en (e.g. a late ack after a timeout)
   assign launch = enable && tx_level != '0 && rx_level != FULL && !drv_en;
   always_comb begin
      state_nx = state;
      drv_start = 1'b0;
      tx_pop = 1'b0;
      rx_push = 1'b0;
      timeout = 1'b0;
      case (state)
         IDLE:      state_nx = launch ? START : IDLE;
         START: begin
            drv_start = 1'b1;
            tx_pop = 1'b1;
            state_nx = WAIT_ACK;
         end
         WAIT_ACK: begin
            timeout = !drv_en && cnt == TO_LIM;
            state_nx = drv_en ? WAIT_DONE : timeout ? GAP : WAIT_ACK;
         end
         WAIT_DONE: begin
            rx_push = !drv_en;
            state_nx = drv_en ? WAIT_DONE : GAP;
         end
         GAP:       state_nx = cnt == GAP_LIM ? IDLE : GAP;
         default:   state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= tx_data;
      if (rx_push) rx_mem[rx_wp] <= last_rx;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
         tx_level <= '0;
         rx_level <= '0;
         last_rx <= '0;
         drv_tx_data <= '0;
         xfer_count <= '0;
         err <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= state != state_nx ? 16'd0 : cnt + 16'd1;
         tx_wp <= tx_wp + AW'(tx_push);
         tx_rp <= tx_rp + AW'(tx_pop);
         rx_wp <= rx_wp + AW'(rx_push);
         rx_rp <= rx_rp + AW'(rx_pop);
         tx_level <= tx_level + LW'(tx_push) - LW'(tx_pop);
         rx_level <= rx_level + LW'(rx_push) - LW'(rx_pop);
         last_rx <= drv_en && (state == WAIT_ACK || state == WAIT_DONE) ? drv_rx_data : last_rx;
         // byte is presented together with the start pulse and held until the next launch
         drv_tx_data <= state == IDLE && launch ? tx_mem[tx_rp] : drv_tx_data;
         xfer_count <= xfer_count + 16'(rx_push);
         err <= timeout || (err && !err_clr);
      end
   end
endmodule
